// File: rtl/int_sched_if.sv
// Bus between the interrupt scheduler, the fetch stage and the interrupt sources.
// The slave modport is the scheduler's view; master is the fetch/core side.
interface int_sched_if;
  logic [3:0]  irq;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        stall_F;
  logic        branch_D;
  logic [31:0] pc_F;
  logic        rti;
  logic        int_take;
  logic [31:0] int_vector;
  logic [1:0]  int_src;
  logic        ret_take;
  logic [31:0] ret_pc;
  logic        in_service;
  logic [3:0]  pending;
  logic [3:0]  mask;

  modport slave (
    input  irq, mask_we, mask_wdata, stall_F, branch_D, pc_F, rti,
    output int_take, int_vector, int_src, ret_take, ret_pc, in_service, pending, mask
  );

  modport master (
    output irq, mask_we, mask_wdata, stall_F, branch_D, pc_F, rti,
    input  int_take, int_vector, int_src, ret_take, ret_pc, in_service, pending, mask
  );
endinterface

// File: rtl/int_sched.sv
// Interrupt scheduler: edge-detects four sources, applies mask and fixed priority,
// redirects fetch only when safe, and sequences the return on rti without nesting.
module int_sched #(
  parameter logic [31:0] IA0 = 32'h00000020,
  parameter logic [31:0] IA1 = 32'h00000020,
  parameter logic [31:0] IA2 = 32'h00000009,
  parameter logic [31:0] IA3 = 32'h00000009
) (
  input logic       clk,
  input logic       reset,
  int_sched_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ARM, TAKE, SERVICE, RETURN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  irq_q;
  logic [3:0]  pending_q, pending_d;
  logic [3:0]  mask_q, mask_d;
  logic [1:0]  int_src_q, int_src_d;
  logic [31:0] int_vector_q, int_vector_d;
  logic [31:0] ret_pc_q, ret_pc_d;
  logic [3:0]  rise, elig;
  logic [1:0]  winner;
  logic [31:0] vec_sel;
  logic        safe;

  assign rise = bus.irq & ~irq_q;
  assign elig = pending_q & mask_q;
  assign safe = ~bus.stall_F & ~bus.branch_D;
  assign mask_d = bus.mask_we ? bus.mask_wdata : mask_q;

  // Bit 0 has the highest priority.
  always_comb begin
    casez (elig)
      4'b???1: winner = 2'd0;
      4'b??10: winner = 2'd1;
      4'b?100: winner = 2'd2;
      4'b1000: winner = 2'd3;
      default: winner = 2'd0;
    endcase
  end

  always_comb begin
    case (winner)
      2'd0:    vec_sel = IA0;
      2'd1:    vec_sel = IA1;
      2'd2:    vec_sel = IA2;
      default: vec_sel = IA3;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | rise;
    int_src_d    = int_src_q;
    int_vector_d = int_vector_q;
    ret_pc_d     = ret_pc_q;
    case (state_q)
      IDLE: begin
        if (elig != 4'b0000) state_d = ARM;
      end
      ARM: begin
        if (elig == 4'b0000) begin
          state_d = IDLE;
        end else if (safe) begin
          state_d      = TAKE;
          int_src_d    = winner;
          int_vector_d = vec_sel;
          ret_pc_d     = bus.pc_F;
          // A fresh edge on the winner's bit in this cycle keeps it pending.
          pending_d    = (pending_q & ~(4'b0001 << winner)) | rise;
        end
      end
      TAKE:    state_d = SERVICE;
      SERVICE: begin
        if (bus.rti) state_d = RETURN;
      end
      RETURN:  state_d = (elig != 4'b0000) ? ARM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      irq_q        <= 4'b0000;
      pending_q    <= 4'b0000;
      mask_q       <= 4'b0000;
      int_src_q    <= 2'd0;
      int_vector_q <= 32'h0;
      ret_pc_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      irq_q        <= bus.irq;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      int_src_q    <= int_src_d;
      int_vector_q <= int_vector_d;
      ret_pc_q     <= ret_pc_d;
    end
  end

  assign bus.int_take   = (state_q == TAKE);
  assign bus.ret_take   = (state_q == RETURN);
  assign bus.in_service = (state_q == TAKE) || (state_q == SERVICE) || (state_q == RETURN);
  assign bus.int_vector = int_vector_q;
  assign bus.int_src    = int_src_q;
  assign bus.ret_pc     = ret_pc_q;
  assign bus.pending    = pending_q;
  assign bus.mask       = mask_q;

endmodule

// File: tb/tb_int_sched.sv
// Self-checking bench for int_sched: a flag-based behavioural model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_int_sched;

  logic clk = 1'b0;
  logic reset;
  int   testsRun = 0;
  int   testsFailed = 0;

  int_sched_if bus();

  int_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] vecTable [4] = '{32'h20, 32'h20, 32'h9, 32'h9};

  logic [3:0]  mPending, mMask, mIrqPrev;
  logic        mHandler, mTakeNow, mRetNow, mArmed;
  logic [1:0]  mSrc;
  logic [31:0] mVector, mRetPc;
  bit          modelValid = 1'b0;

  function automatic int lowestSet(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++)
      if (v[i] && r < 0) r = i;
    return r;
  endfunction

  logic [3:0] mRise, mElig, mClr;
  int         mFirst;
  logic       mTakeGo;

  always_comb begin
    mRise   = bus.irq & ~mIrqPrev;
    mElig   = mPending & mMask;
    mFirst  = lowestSet(mElig);
    mTakeGo = !mTakeNow && !mRetNow && !mHandler && mArmed && (mFirst >= 0)
              && !bus.stall_F && !bus.branch_D;
    mClr    = mTakeGo ? (4'b0001 << mFirst[1:0]) : 4'b0000;
  end

  // Model: a handler is "running" from the take pulse through the return pulse.
  always @(posedge clk) begin
    if (reset) begin
      mPending <= '0; mMask <= '0; mIrqPrev <= '0;
      mHandler <= 1'b0; mTakeNow <= 1'b0; mRetNow <= 1'b0; mArmed <= 1'b0;
      mSrc <= '0; mVector <= '0; mRetPc <= '0;
      modelValid <= 1'b1;
    end else begin
      mIrqPrev <= bus.irq;
      mMask    <= bus.mask_we ? bus.mask_wdata : mMask;
      mPending <= (mPending & ~mClr) | mRise;
      if (mTakeNow) begin
        mTakeNow <= 1'b0;
      end else if (mRetNow) begin
        mRetNow  <= 1'b0;
        mHandler <= 1'b0;
        mArmed   <= (mFirst >= 0);
      end else if (mHandler) begin
        if (bus.rti) mRetNow <= 1'b1;
      end else if (mArmed) begin
        if (mFirst < 0) begin
          mArmed <= 1'b0;
        end else if (mTakeGo) begin
          mArmed   <= 1'b0;
          mTakeNow <= 1'b1;
          mHandler <= 1'b1;
          mSrc     <= mFirst[1:0];
          mVector  <= vecTable[mFirst];
          mRetPc   <= bus.pc_F;
        end
      end else begin
        mArmed <= (mFirst >= 0);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("model.int_take",   32'(bus.int_take),   32'(mTakeNow));
      checkOutput("model.ret_take",   32'(bus.ret_take),   32'(mRetNow));
      checkOutput("model.in_service", 32'(bus.in_service), 32'(mHandler));
      checkOutput("model.int_vector", bus.int_vector,      mVector);
      checkOutput("model.int_src",    32'(bus.int_src),    32'(mSrc));
      checkOutput("model.ret_pc",     bus.ret_pc,          mRetPc);
      checkOutput("model.pending",    32'(bus.pending),    32'(mPending));
      checkOutput("model.mask",       32'(bus.mask),       32'(mMask));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] irqV, input logic stallV,
                               input logic branchV, input logic rtiV);
    bus.irq      = irqV;
    bus.stall_F  = stallV;
    bus.branch_D = branchV;
    bus.rti      = rtiV;
  endtask

  task automatic writeMask(input logic [3:0] m);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = m;
    cyc();
    bus.mask_we    = 1'b0;
  endtask

  // Leaves SERVICE via rti; returns with the RETURN cycle just completed.
  task automatic finishHandler();
    cyc();
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    cyc();
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("ret_take", 32'(bus.ret_take), 32'd1);
    cyc();
  endtask

  initial begin
    reset          = 1'b1;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = 4'b0000;
    bus.pc_F       = 32'h0;
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
    checkOutput("reset.int_take",   32'(bus.int_take),   32'd0);
    checkOutput("reset.in_service", 32'(bus.in_service), 32'd0);
    checkOutput("reset.pending",    32'(bus.pending),    32'd0);
    checkOutput("reset.mask",       32'(bus.mask),       32'd0);
    checkOutput("reset.ret_pc",     bus.ret_pc,          32'd0);

    // Single take of irq[2].
    writeMask(4'b1111);
    bus.pc_F = 32'h100;
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    cyc();
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    cyc();
    cyc();
    checkOutput("single.int_take",   32'(bus.int_take), 32'd1);
    checkOutput("single.int_vector", bus.int_vector,    32'h9);
    checkOutput("single.int_src",    32'(bus.int_src),  32'd2);
    checkOutput("single.ret_pc",     bus.ret_pc,        32'h100);
    checkOutput("single.pending",    32'(bus.pending),  32'd0);
    finishHandler();
    checkOutput("single.idle", 32'(bus.in_service), 32'd0);

    // Preemption while stalled in ARM.
    bus.pc_F = 32'h200;
    applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
    cyc();
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    cyc();
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
    cyc();
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    cyc();
    checkOutput("preempt.stalled", 32'(bus.int_take), 32'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    cyc();
    checkOutput("preempt.int_take",   32'(bus.int_take), 32'd1);
    checkOutput("preempt.int_src",    32'(bus.int_src),  32'd0);
    checkOutput("preempt.int_vector", bus.int_vector,    32'h20);
    checkOutput("preempt.pending",    32'(bus.pending),  32'b1000);
    finishHandler();
    checkOutput("preempt.arm", 32'(bus.int_take), 32'd0);
    cyc();
    checkOutput("preempt.second_take", 32'(bus.int_take), 32'd1);
    checkOutput("preempt.second_src",  32'(bus.int_src),  32'd3);
    finishHandler();

    // Branch in decode blocks the redirect.
    applyStimulus(4'b0010, 1'b0, 1'b1, 1'b0);
    cyc();
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      checkOutput("branch.blocked", 32'(bus.int_take), 32'd0);
    end
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    cyc();
    checkOutput("branch.int_take", 32'(bus.int_take), 32'd1);
    checkOutput("branch.int_src",  32'(bus.int_src),  32'd1);
    finishHandler();

    // Masked source stays pending until enabled.
    writeMask(4'b0000);
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
    cyc();
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    cyc();
    cyc();
    checkOutput("mask.pending",  32'(bus.pending),  32'b0010);
    checkOutput("mask.no_take",  32'(bus.int_take), 32'd0);
    writeMask(4'b0010);
    checkOutput("mask.wait0", 32'(bus.int_take), 32'd0);
    cyc();
    checkOutput("mask.wait1", 32'(bus.int_take), 32'd0);
    cyc();
    checkOutput("mask.int_take", 32'(bus.int_take), 32'd1);
    checkOutput("mask.int_src",  32'(bus.int_src),  32'd1);
    finishHandler();

    // Mask cleared while waiting in ARM.
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
    cyc();
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    cyc();
    writeMask(4'b0000);
    cyc();
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    cyc();
    cyc();
    checkOutput("maskclr.no_take", 32'(bus.int_take),   32'd0);
    checkOutput("maskclr.idle",    32'(bus.in_service), 32'd0);
    checkOutput("maskclr.pending", 32'(bus.pending),    32'b0010);

    // No nesting while in service.
    writeMask(4'b1111);
    cyc();
    cyc();
    checkOutput("nest.take1", 32'(bus.int_take), 32'd1);
    cyc();
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    cyc();
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    cyc();
    checkOutput("nest.in_service", 32'(bus.in_service), 32'd1);
    checkOutput("nest.pending",    32'(bus.pending),    32'b0001);
    checkOutput("nest.no_take",    32'(bus.int_take),   32'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    cyc();
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    cyc();
    cyc();
    checkOutput("nest.take2_src", 32'(bus.int_src), 32'd0);
    finishHandler();

    // Stray rti while idle.
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    cyc();
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("stray.ret_take0", 32'(bus.ret_take), 32'd0);
    cyc();
    checkOutput("stray.ret_take1", 32'(bus.ret_take), 32'd0);

    // Edge on the winner's bit in the cycle it is cleared keeps it pending.
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
    cyc();
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    cyc();
    cyc();
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    cyc();
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("collide.int_take", 32'(bus.int_take), 32'd1);
    checkOutput("collide.pending",  32'(bus.pending),  32'b0100);
    finishHandler();
    cyc();
    checkOutput("collide.retake",   32'(bus.int_take), 32'd1);
    checkOutput("collide.pending2", 32'(bus.pending),  32'b0000);
    finishHandler();

    // Reset during TAKE.
    bus.pc_F = 32'h300;
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    cyc();
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    cyc();
    cyc();
    checkOutput("rst.take", 32'(bus.int_take), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checkOutput("rst.int_take",   32'(bus.int_take),   32'd0);
    checkOutput("rst.ret_take",   32'(bus.ret_take),   32'd0);
    checkOutput("rst.in_service", 32'(bus.in_service), 32'd0);
    checkOutput("rst.int_vector", bus.int_vector,      32'd0);
    checkOutput("rst.int_src",    32'(bus.int_src),    32'd0);
    checkOutput("rst.ret_pc",     bus.ret_pc,          32'd0);
    checkOutput("rst.pending",    32'(bus.pending),    32'd0);
    checkOutput("rst.mask",       32'(bus.mask),       32'd0);
    cyc();
    cyc();
    checkOutput("rst.stays_idle", 32'(bus.in_service), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/int_sched.md
# int_sched

Interrupt scheduler for the pipelined CPU core. Edge-detects four interrupt sources (two IO lines, two counter timeouts), latches them as pending, applies a software-written enable mask and fixed priority, and redirects fetch to the winning vector only when the front end is safe to redirect. It saves the interrupted fetch PC, blocks nesting while a handler runs, and sequences the return on `rti`. It sits between the counters/IO pins and the fetch stage, replacing ad-hoc interrupt priority logic in fetch.

## Interface
- `IA0`, default 32'h00000020: vector for `irq[0]` (IO interrupt 0)
- `IA1`, default 32'h00000020: vector for `irq[1]` (IO interrupt 1)
- `IA2`, default 32'h00000009: vector for `irq[2]` (counter 0)
- `IA3`, default 32'h00000009: vector for `irq[3]` (counter 1)

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `irq` in 4: raw request levels; bit 0 has the highest priority.
- `mask_we` in 1: write strobe for the enable mask.
- `mask_wdata` in 4: new mask value; 1 = source enabled.
- `stall_F` in 1: fetch stalled; a redirect is not allowed in this cycle.
- `branch_D` in 1: branch or jump in decode; a redirect is not allowed in this cycle.
- `pc_F` in 32: current fetch PC; this is the value saved as the return address.
- `rti` in 1: return-from-interrupt decoded.
- `int_take` out 1: one-cycle pulse; fetch loads `int_vector`.
- `int_vector` out 32: vector of the taken source.
- `int_src` out 2: index of the taken source.
- `ret_take` out 1: one-cycle pulse; fetch loads `ret_pc`.
- `ret_pc` out 32: saved return PC.
- `in_service` out 1: handler active; this is the exception-active indication.
- `pending` out 4: pending bits, readable by the core.
- `mask` out 4: current enable mask.

## Operation
- Edge detect: `irq_q` is `irq` registered. A rising edge on bit i (`irq[i] & ~irq_q[i]`) sets `pending[i]`. This happens in every state and regardless of the mask.
- Eligible set: `elig = pending & mask`. The winner is the lowest-index set bit of `elig`.
- Safe condition: `safe = ~stall_F & ~branch_D`.
- States: IDLE, ARM, TAKE, SERVICE, RETURN.
  - IDLE: if `elig != 0`, go to ARM.
  - ARM:
    - If `elig == 0` (the mask was cleared meanwhile), go to IDLE.
    - Else if `safe`, go to TAKE. On this transition, register `int_src` = winner, `int_vector` = IA[winner], `ret_pc` = `pc_F`, and clear `pending[winner]`.
    - Else stay in ARM and re-evaluate the winner every cycle, so a higher-priority arrival preempts the pending choice.
  - TAKE: lasts exactly one cycle. `int_take` = 1, `in_service` = 1. Next state is SERVICE.
  - SERVICE: `in_service` = 1. There is no nesting; new edges only accumulate in `pending`. `rti` moves to RETURN.
  - RETURN: lasts exactly one cycle. `ret_take` = 1, `in_service` = 1. Next state is ARM if `elig != 0`, else IDLE.
- `rti` outside SERVICE is ignored.
- Mask: `mask <= mask_wdata` when `mask_we` is high, in any state. The write affects `elig` from the next cycle.
- Set/clear collision: if an edge on the winner's bit arrives in the same cycle that bit is cleared at ARM→TAKE, the set wins and the bit stays pending.
- Reset in any state: returns to IDLE on the next edge. An in-flight TAKE or RETURN pulse is dropped and `ret_pc` is lost.

## Timing
- Reset values:
  - State = IDLE.
  - `int_take`, `ret_take`, `in_service` = 0.
  - `int_vector`, `ret_pc` = 0.
  - `int_src` = 0, `pending` = 0, `mask` = 0 (all sources disabled), `irq_q` = 0.
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- Latency, with the edge sampled at cycle 0, mask enabled, and `safe` high:
  - `pending` visible at cycle 1.
  - ARM at cycle 2.
  - `int_take` high at cycle 3.
  - Each unsafe cycle spent in ARM adds one cycle.
- `rti` sampled at cycle n gives `ret_take` high at cycle n+1.
- With another source already pending, the next `int_take` follows `ret_take` after 2 cycles: RETURN → ARM → TAKE.
- `int_vector`, `int_src` and `ret_pc` hold their values from TAKE until the next TAKE.

## Test plan
- Reset and single take: reset, then `mask` = 4'b1111, `pc_F` = 32'h100, pulse `irq[2]` -> `int_take` 3 cycles later, `int_vector` = 32'h9, `int_src` = 2, `ret_pc` = 32'h100, `pending` = 0.
- Priority and preemption:
  - `irq[3]` rises with `stall_F` held high in ARM; `irq[0]` rises 2 cycles later; release `stall_F` -> TAKE with `int_src` = 0, `int_vector` = 32'h20, `pending` = 4'b1000.
  - After `rti`: `ret_take`, then `int_take` with `int_src` = 3 two cycles later.
- Safety gating: hold `branch_D` = 1 for 5 cycles while in ARM -> no `int_take` during them; `int_take` fires the cycle after `branch_D` falls.
- Masking:
  - `mask` = 0, pulse `irq[1]` -> `pending[1]` = 1, no take.
  - Write `mask` = 4'b0010 -> `int_take` 2 cycles after the write, `int_src` = 1.
  - Clearing the mask while in ARM -> return to IDLE with no take.
- No nesting and stray `rti`:
  - In SERVICE, pulse `irq[0]` -> `in_service` stays 1, `pending[0]` = 1, no `int_take`.
  - `rti` while in IDLE -> no `ret_take`.
- Reset mid-operation: assert `reset` during TAKE -> next cycle all outputs are at their reset values and state = IDLE.
